// File: rtl/sram_arbiter_pkg.sv
// Shared arbiter definitions: state enum, port indices, default parameters
// and the round-robin pick helper.
package sram_arbiter_pkg;

  typedef enum logic {S_ARB_IDLE, S_ARB_OWN} sram_arb_state_type;

  localparam logic [1:0] ARB_UART = 2'd0;
  localparam logic [1:0] ARB_M1   = 2'd1;
  localparam logic [1:0] ARB_VGA  = 2'd2;
  localparam logic [1:0] ARB_NONE = 2'd3;

  localparam int DEFAULT_READ_LATENCY = 3;
  localparam int DEFAULT_MAX_BURST    = 16;

  // First requesting port after 'last', wrapping 2 -> 0; ARB_NONE if none.
  function automatic logic [1:0] rr_next(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = ARB_NONE;
    idx  = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx >= ARB_VGA) ? ARB_UART : idx + 2'd1;
      if (pick == ARB_NONE && req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_arb_tag_pipe.sv
// Read-return tag delay line: a one-hot port tag emerges READ_LATENCY cycles
// after the read address was presented to the SRAM controller.
import sram_arbiter_pkg::*;

module sram_arb_tag_pipe #(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic       Clock_50,
  input  logic       Reset,
  input  logic [2:0] tag_in,
  output logic [2:0] tag_out
);

  logic [2:0] stage [READ_LATENCY];

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      for (int i = 0; i < READ_LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < READ_LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[READ_LATENCY-1];

endmodule

// File: rtl/sram_arbiter.sv
// Three-port round-robin SRAM arbiter with lockable bursts and a turnaround
// cycle between owners. Define SRAM_ARB_STATS_EN to add per-port grant_count.
//
// state      | meaning
// S_ARB_IDLE | no owner; picks the next requester round-robin
// S_ARB_OWN  | one port owns the SRAM until it releases or is pre-empted
import sram_arbiter_pkg::*;

module sram_arbiter #(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY,
  parameter int MAX_BURST    = DEFAULT_MAX_BURST
) (
  input  logic             Clock_50,
  input  logic             Reset,
  input  logic [2:0]       req,
  input  logic [2:0]       lock,
  input  logic [2:0][17:0] port_address,
  input  logic [2:0][15:0] port_write_data,
  input  logic [2:0]       port_we_n,
  output logic [2:0]       gnt,
  output logic [2:0]       rd_valid,
  output logic [15:0]      rd_data,
  output logic [17:0]      SRAM_address,
  output logic [15:0]      SRAM_write_data,
  output logic             SRAM_we_n,
  input  logic [15:0]      SRAM_read_data,
  output logic [1:0]       owner
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [2:0][15:0] grant_count
`endif
);

  localparam logic [4:0] BURST_LAST = 5'(MAX_BURST - 1);

  sram_arb_state_type state;
  logic [1:0]  last_owner;
  logic [1:0]  next_pick;
  logic [1:0]  sel;
  logic [4:0]  burst_cnt;
  logic [17:0] address_hold;
  logic [15:0] write_data_hold;
  logic        access;
  logic        others_pending;
  logic        sel_we_n;

  // sel is only meaningful while gnt is set; clamp so the index stays legal
  assign sel            = (owner == ARB_NONE) ? ARB_UART : owner;
  assign sel_we_n       = port_we_n[sel];
  assign access         = |(gnt & req);
  assign others_pending = |(req & ~gnt);
  assign next_pick      = rr_next(last_owner, req);

  always_comb begin
    SRAM_address    = address_hold;
    SRAM_write_data = write_data_hold;
    SRAM_we_n       = 1'b1;
    if (access) begin
      SRAM_address    = port_address[sel];
      SRAM_write_data = port_write_data[sel];
      SRAM_we_n       = sel_we_n;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state           <= S_ARB_IDLE;
      gnt             <= '0;
      owner           <= ARB_NONE;
      last_owner      <= ARB_VGA;
      burst_cnt       <= '0;
      address_hold    <= '0;
      write_data_hold <= '0;
    end else begin
      if (access) begin
        address_hold    <= port_address[sel];
        write_data_hold <= port_write_data[sel];
      end
      case (state)
        S_ARB_IDLE: begin
          if (|req) begin
            state     <= S_ARB_OWN;
            owner     <= next_pick;
            gnt       <= 3'b001 << next_pick;
            burst_cnt <= '0;
          end
        end
        S_ARB_OWN: begin
          if (!req[sel] || (others_pending && (!lock[sel] || burst_cnt == BURST_LAST))) begin
            state      <= S_ARB_IDLE;
            gnt        <= '0;
            last_owner <= owner;
            owner      <= ARB_NONE;
          end else if (others_pending && burst_cnt != BURST_LAST) begin
            burst_cnt <= burst_cnt + 5'd1;
          end
        end
        default: state <= S_ARB_IDLE;
      endcase
    end
  end

  sram_arb_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_tag_pipe (
    .Clock_50 (Clock_50),
    .Reset    (Reset),
    .tag_in   (gnt & req & {3{sel_we_n}}),
    .tag_out  (rd_valid)
  );

  assign rd_data = SRAM_read_data;

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      grant_count <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (gnt[i] && req[i] && grant_count[i] != 16'hFFFF)
          grant_count[i] <= grant_count[i] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with an SRAM controller model and a
// behavioural arbitration model for the randomized run.
`timescale 1ns/1ps
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int LAT = 3;
  localparam int MB  = 16;

  logic             Clock_50 = 1'b0;
  logic             Reset;
  logic [2:0]       req, lock, port_we_n;
  logic [2:0][17:0] port_address;
  logic [2:0][15:0] port_write_data;
  logic [2:0]       gnt, rd_valid;
  logic [15:0]      rd_data, SRAM_write_data, SRAM_read_data;
  logic [17:0]      SRAM_address;
  logic             SRAM_we_n;
  logic [1:0]       owner;
`ifdef SRAM_ARB_STATS_EN
  logic [2:0][15:0] grant_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sram_arbiter #(.READ_LATENCY(LAT), .MAX_BURST(MB)) dut (
    .Clock_50        (Clock_50),
    .Reset           (Reset),
    .req             (req),
    .lock            (lock),
    .port_address    (port_address),
    .port_write_data (port_write_data),
    .port_we_n       (port_we_n),
    .gnt             (gnt),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n),
    .SRAM_read_data  (SRAM_read_data),
    .owner           (owner)
`ifdef SRAM_ARB_STATS_EN
    ,
    .grant_count     (grant_count)
`endif
  );

  always #10 Clock_50 = ~Clock_50;

  // SRAM controller model: write on the edge, read data LAT cycles after address
  logic [15:0] mem [logic [17:0]];
  logic [15:0] rd_pipe [LAT];

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ {a[17:16], 14'h1A5B};
  endfunction

  always @(posedge Clock_50) begin
    rd_pipe[0] <= mem_word(SRAM_address);
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (SRAM_we_n === 1'b0) mem[SRAM_address] = SRAM_write_data;
  end
  assign SRAM_read_data = rd_pipe[LAT-1];

  task automatic next_cycle();
    @(posedge Clock_50);
    #1;
  endtask

  task automatic do_reset();
    req = '0; lock = '0; port_we_n = 3'b111;
    port_address = '0; port_write_data = '0;
    Reset = 1'b1;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge Clock_50);
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b expected 000", gnt); end
    n_checks++; if (owner !== ARB_NONE) begin n_fail++; $display("FAIL reset_owner: got %0d expected 3", owner); end
    n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b expected 1", SRAM_we_n); end
    n_checks++; if (SRAM_address !== 18'h0) begin n_fail++; $display("FAIL reset_address: got %h expected 0", SRAM_address); end
    n_checks++; if (SRAM_write_data !== 16'h0) begin n_fail++; $display("FAIL reset_write_data: got %h expected 0", SRAM_write_data); end
    n_checks++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 000", rd_valid); end
`ifdef SRAM_ARB_STATS_EN
    n_checks++; if (grant_count !== '0) begin n_fail++; $display("FAIL reset_grant_count: got %h expected 0", grant_count); end
`endif
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    do_reset();
    req = 3'b111;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock_50);
      n_checks++;
      if (gnt !== exp_seq[c]) begin n_fail++; $display("FAIL rr_cycle%0d: got %b expected %b", c, gnt, exp_seq[c]); end
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_burst_lock();
    int held;
    do_reset();
    req = 3'b010; lock = 3'b010;
    next_cycle();
    req = 3'b011;
    held = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock_50);
      if (gnt !== 3'b010) break;
      held++;
      next_cycle();
    end
    n_checks++; if (held != MB) begin n_fail++; $display("FAIL burst_length: got %0d expected %0d", held, MB); end
    n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL burst_turnaround: got %b expected 000", gnt); end
    next_cycle();
    @(negedge Clock_50);
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL burst_next_owner: got %b expected 001", gnt); end
    next_cycle();
    req = '0; lock = '0;
  endtask

  task automatic test_read_return();
    logic [2:0] exp_v;
    do_reset();
    port_address[2] = 18'd146944; req = 3'b100;
    next_cycle();
    @(negedge Clock_50);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL read_grant: got %b expected 100", gnt); end
    next_cycle();
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge Clock_50);
      exp_v = (k == LAT) ? 3'b100 : 3'b000;
      n_checks++;
      if (rd_valid !== exp_v) begin n_fail++; $display("FAIL read_valid_n+%0d: got %b expected %b", k, rd_valid, exp_v); end
      if (k == LAT) begin
        n_checks++;
        if (rd_data !== mem_word(18'd146944)) begin n_fail++; $display("FAIL read_data: got %h expected %h", rd_data, mem_word(18'd146944)); end
      end
      next_cycle();
    end
  endtask

  task automatic test_write_readback();
    bit got;
    do_reset();
    port_address[0] = 18'h00010; port_write_data[0] = 16'hABCD; port_we_n = 3'b110; req = 3'b001;
    @(negedge Clock_50);
    n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL wr_before_grant: got %b expected 1", SRAM_we_n); end
    next_cycle();
    @(negedge Clock_50);
    n_checks++; if (SRAM_we_n !== 1'b0) begin n_fail++; $display("FAIL wr_we_n: got %b expected 0", SRAM_we_n); end
    n_checks++; if (SRAM_address !== 18'h00010) begin n_fail++; $display("FAIL wr_address: got %h expected 00010", SRAM_address); end
    n_checks++; if (SRAM_write_data !== 16'hABCD) begin n_fail++; $display("FAIL wr_data: got %h expected abcd", SRAM_write_data); end
    next_cycle();
    req = 3'b010; port_address[1] = 18'h00010;
    @(negedge Clock_50);
    n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL wr_after_drop: got %b expected 1", SRAM_we_n); end
    n_checks++; if (SRAM_address !== 18'h00010) begin n_fail++; $display("FAIL addr_hold: got %h expected 00010", SRAM_address); end
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (gnt[1] === 1'b1) begin got = 1; break; end
      next_cycle();
      @(negedge Clock_50);
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rb_grant_timeout: got none expected gnt 010"); end
    next_cycle();
    req = '0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clock_50);
      if (rd_valid === 3'b010) begin got = 1; break; end
      next_cycle();
    end
    n_checks++; if (!got) begin n_fail++; $display("FAIL rb_valid_timeout: got none expected rd_valid 010"); end
    n_checks++; if (rd_data !== 16'hABCD) begin n_fail++; $display("FAIL rb_data: got %h expected abcd", rd_data); end
    next_cycle();
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    port_address[2] = 18'h00123; req = 3'b100;
    next_cycle();
    @(negedge Clock_50);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL rif_issue: got %b expected 100", gnt); end
    next_cycle();
    req = '0; Reset = 1'b1;
    next_cycle();
    Reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock_50);
      n_checks++; if (gnt !== 3'b000) begin n_fail++; $display("FAIL rif_gnt%0d: got %b expected 000", k, gnt); end
      n_checks++; if (SRAM_we_n !== 1'b1) begin n_fail++; $display("FAIL rif_we_n%0d: got %b expected 1", k, SRAM_we_n); end
      n_checks++; if (rd_valid !== 3'b000) begin n_fail++; $display("FAIL rif_rd_valid%0d: got %b expected 000", k, rd_valid); end
      next_cycle();
    end
  endtask

  task automatic test_random();
    int m_owner, m_last, m_run;
    int waiting [3];
    int sb_count [3];
    logic [2:0] tagq [$];
    logic [2:0] exp_g, exp_v, issued;
    logic exp_we, acc, others;
    do_reset();
    m_owner = -1; m_last = 2; m_run = 0;
    for (int i = 0; i < 3; i++) begin waiting[i] = 0; sb_count[i] = 0; end
    tagq = '{3'b000, 3'b000, 3'b000};
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
        else if (m_owner == i && $urandom_range(0, 5) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
        port_we_n[i]       = ($urandom_range(0, 2) != 0);
        port_address[i]    = 18'($urandom);
        port_write_data[i] = 16'($urandom);
      end
      @(negedge Clock_50);
      exp_g  = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
      acc    = (m_owner >= 0) && req[m_owner];
      exp_we = acc ? port_we_n[m_owner] : 1'b1;
      issued = (acc && port_we_n[m_owner]) ? exp_g : 3'b000;
      n_checks++; if (gnt !== exp_g) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b expected %b", cyc, gnt, exp_g); end
      n_checks++; if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rnd_onehot@%0d: got %b expected at most one bit", cyc, gnt); end
      n_checks++; if (SRAM_we_n !== exp_we) begin n_fail++; $display("FAIL rnd_we_n@%0d: got %b expected %b", cyc, SRAM_we_n, exp_we); end
      if (acc) begin
        n_checks++;
        if (SRAM_address !== port_address[m_owner]) begin n_fail++; $display("FAIL rnd_address@%0d: got %h expected %h", cyc, SRAM_address, port_address[m_owner]); end
      end
      exp_v = tagq.pop_front();
      tagq.push_back(issued);
      n_checks++; if (rd_valid !== exp_v) begin n_fail++; $display("FAIL rnd_rd_valid@%0d: got %b expected %b", cyc, rd_valid, exp_v); end
      for (int i = 0; i < 3; i++) begin
        waiting[i] = (req[i] && !gnt[i]) ? waiting[i] + 1 : 0;
        n_checks++;
        if (waiting[i] > 2 * (MB + 1)) begin n_fail++; $display("FAIL rnd_starve_port%0d@%0d: got wait %0d expected <= %0d", i, cyc, waiting[i], 2 * (MB + 1)); end
      end
`ifdef SRAM_ARB_STATS_EN
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (grant_count[i] !== 16'(sb_count[i])) begin n_fail++; $display("FAIL rnd_grant_count%0d@%0d: got %0d expected %0d", i, cyc, grant_count[i], sb_count[i]); end
      end
`endif
      if (acc && sb_count[m_owner] < 65535) sb_count[m_owner]++;
      // next owner from the arbitration rules
      if (m_owner < 0) begin
        if (req != 3'b000) begin
          for (int k = 1; k <= 3; k++)
            if (m_owner < 0 && req[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
          m_run = 0;
        end
      end else begin
        others = (req & ~exp_g) != 3'b000;
        if (!req[m_owner] || (others && (!lock[m_owner] || m_run == MB - 1))) begin
          m_last = m_owner; m_owner = -1;
        end else if (others && m_run < MB - 1) begin
          m_run++;
        end
      end
      next_cycle();
      if (n_fail > 50) break;
    end
    req = '0; lock = '0;
  endtask

  initial begin
    Reset = 1'b1; req = '0; lock = '0; port_we_n = 3'b111;
    port_address = '0; port_write_data = '0;
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_read_return();
    test_write_readback();
    test_reset_in_flight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
